// File: rtl/nn_sld_pkg.sv
// Shared definitions for the sliding-window job sequencer: mode encodings,
// kernel depths and the controller state type.
package nn_sld_pkg;

  localparam logic [1:0] MODE_3X3 = 2'b00;
  localparam logic [1:0] MODE_6A  = 2'b01;
  localparam logic [1:0] MODE_6B  = 2'b10;
  localparam logic [1:0] MODE_6C  = 2'b11;

  localparam int K_3X3 = 3;
  localparam int K_6   = 6;
  localparam int K_W   = 3;

  typedef logic [K_W-1:0] depth_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_SLIDE,
    ST_HOLD,
    ST_FIN
  } state_t;

  // Every 6-deep mode shares the same window depth; only 3x3 differs.
  function automatic depth_t kernel_depth(input logic [1:0] mode);
    return (mode == MODE_3X3) ? depth_t'(K_3X3) : depth_t'(K_6);
  endfunction

endpackage

// File: rtl/nn_sld_ctrl_if.sv
// Bundle between the layer scheduler / PE array side (master) and the
// sliding-window job sequencer (slave).
interface nn_sld_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int COL_W  = 8
);

  logic              i_start;
  logic [1:0]        i_mode;
  logic              i_3x3;
  logic [COL_W-1:0]  i_cols;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_pe_ready;

  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              o_shift;
  logic [1:0]        o_mode;
  logic              o_3x3;
  logic              o_win_valid;
  logic [COL_W-1:0]  o_win_idx;

  modport master (
    output i_start, i_mode, i_3x3, i_cols, i_base_addr, i_pe_ready,
    input  o_busy, o_done, o_rd_en, o_rd_addr, o_shift,
           o_mode, o_3x3, o_win_valid, o_win_idx
  );

  modport slave (
    input  i_start, i_mode, i_3x3, i_cols, i_base_addr, i_pe_ready,
    output o_busy, o_done, o_rd_en, o_rd_addr, o_shift,
           o_mode, o_3x3, o_win_valid, o_win_idx
  );

endinterface

// File: rtl/nn_sld_addr_gen.sv
// Input-buffer read address counter: loads the job base, advances once per
// issued read (wrapping naturally) and counts reads issued in the job.
module nn_sld_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic [CNT_W-1:0]  o_count
);

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;

  // NOTE: only control state lives here, so every flop takes the synchronous
  // reset; a data-path memory would be left unreset to keep it cheap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      count_q <= '0;
    end else if (i_load) begin
      addr_q  <= i_base;
      count_q <= '0;
    end else if (i_inc) begin
      addr_q  <= addr_q + ADDR_W'(1);
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign o_addr  = addr_q;
  assign o_count = count_q;

endmodule

// File: rtl/nn_sld_ctrl.sv
// Sliding-window job sequencer: preloads K columns into the register file,
// then slides one column per accepted window while holding under backpressure.
module nn_sld_ctrl
  import nn_sld_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int COL_W  = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  nn_sld_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic              h3_q;
  depth_t            k_q;
  logic [COL_W-1:0]  nw_q;
  logic [COL_W-1:0]  win_idx_q;
  logic              shift_q;

  logic              start_acc;
  logic              accept;
  logic              last_win;
  logic              preload_last;
  logic              rd_en;
  depth_t            k_new;
  logic [COL_W-1:0]  nw_new;
  logic [ADDR_W-1:0] rd_addr;
  logic [COL_W-1:0]  rd_count;

  // Window count is fixed at start so the slide loop needs no column counter.
  assign k_new  = kernel_depth(bus.i_mode);
  assign nw_new = (bus.i_cols >= COL_W'(k_new))
                ? bus.i_cols - COL_W'(k_new) + COL_W'(1)
                : '0;

  assign start_acc    = (state_q == ST_IDLE) && bus.i_start;
  assign accept       = (state_q == ST_HOLD) && bus.i_pe_ready;
  assign last_win     = (win_idx_q == nw_q - COL_W'(1));
  assign preload_last = (rd_count == COL_W'(k_q) - COL_W'(1));

  nn_sld_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (COL_W)
  ) u_addr_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (start_acc),
    .i_base  (bus.i_base_addr),
    .i_inc   (rd_en),
    .o_addr  (rd_addr),
    .o_count (rd_count)
  );

  // NOTE: defaults are assigned before the case so no path leaves a signal
  // unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) state_d = (nw_new == '0) ? ST_FIN : ST_PRELOAD;
      end
      ST_PRELOAD: begin
        rd_en = 1'b1;
        if (preload_last) state_d = ST_SLIDE;
      end
      ST_SLIDE: begin
        if (shift_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // The next column read goes out in the acceptance cycle itself.
        if (bus.i_pe_ready) begin
          if (last_win) begin
            state_d = ST_FIN;
          end else begin
            rd_en   = 1'b1;
            state_d = ST_SLIDE;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= 1'b0;
      mode_q    <= '0;
      h3_q      <= 1'b0;
      k_q       <= '0;
      nw_q      <= '0;
      win_idx_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= rd_en;
      if (start_acc) begin
        mode_q    <= bus.i_mode;
        h3_q      <= bus.i_3x3;
        k_q       <= k_new;
        nw_q      <= nw_new;
        win_idx_q <= '0;
      end else if (accept && !last_win) begin
        win_idx_q <= win_idx_q + COL_W'(1);
      end
    end
  end

  assign bus.o_busy      = state_q inside {ST_PRELOAD, ST_SLIDE, ST_HOLD};
  assign bus.o_done      = (state_q == ST_FIN);
  assign bus.o_rd_en     = rd_en;
  assign bus.o_rd_addr   = rd_addr;
  assign bus.o_shift     = shift_q;
  assign bus.o_mode      = mode_q;
  assign bus.o_3x3       = h3_q;
  assign bus.o_win_valid = (state_q == ST_HOLD);
  assign bus.o_win_idx   = win_idx_q;

  a_done_single: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.o_done |=> !bus.o_done);

  a_no_read_when_idle: assert property (@(posedge i_clk) disable iff (i_rst)
    !bus.o_busy |-> !bus.o_rd_en);

  a_hold_is_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (bus.o_win_valid && !bus.i_pe_ready) |-> (!bus.o_rd_en && !bus.o_shift));

  a_idx_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.o_win_valid |-> (win_idx_q < nw_q));

endmodule

// File: tb/tb_nn_sld_ctrl.sv
// Self-checking bench for nn_sld_ctrl: directed and random jobs compared
// cycle by cycle against an event-timeline model of the sequencer.
module tb_nn_sld_ctrl;
  import nn_sld_pkg::*;

  localparam int ADDR_W = 10;
  localparam int COL_W  = 8;
  localparam int MAXC   = 2048;
  localparam int AMOD   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_sld_ctrl_if #(.ADDR_W(ADDR_W), .COL_W(COL_W)) bus ();

  nn_sld_ctrl #(.ADDR_W(ADDR_W), .COL_W(COL_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  bit          rdy    [MAXC];
  bit          exp_rd [MAXC];
  int          exp_ad [MAXC];
  bit          exp_val[MAXC];
  int          exp_idx[MAXC];
  logic [25:0] exp_tr [MAXC];
  logic [25:0] act_tr [MAXC];
  logic        act_rd [MAXC];
  logic [9:0]  act_ad [MAXC];
  logic        act_sh [MAXC];

  logic [1:0] prev_mode = 2'b00;
  logic       prev_h3   = 1'b0;

  // One observable cycle: address and index only matter when qualified.
  function automatic logic [25:0] pack_tr(input logic rd, input logic [9:0] ad,
      input logic sh, input logic v, input logic [7:0] idx, input logic d,
      input logic b, input logic [1:0] m, input logic h);
    return {rd, (rd === 1'b1) ? ad : 10'd0, sh, v, (v === 1'b1) ? idx : 8'd0, d, b, m, h};
  endfunction

  task automatic set_ready_all();
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
  endtask

  task automatic set_ready_gap(input int lo, input int hi);
    for (int c = 0; c < MAXC; c++) rdy[c] = !(c >= lo && c <= hi);
  endtask

  task automatic set_ready_rand(input int p);
    for (int c = 0; c < MAXC; c++) rdy[c] = (c >= 1000) || ($urandom_range(0, 3) < p);
  endtask

  // Runs one job whose start is sampled at the end of its cycle 0 and
  // compares every cycle up to and including the done cycle.
  task automatic run_job(input string tag, input logic [1:0] mode, input logic h3,
      input int cols, input int base, input bit junk,
      output int done_c, output int n_rd, output int n_sh, output int n_win);
    int k, nw, t, a, ed, nrd, fm;
    for (int c = 0; c < MAXC; c++) begin
      exp_rd[c] = 0; exp_ad[c] = 0; exp_val[c] = 0; exp_idx[c] = 0;
    end
    k   = (mode == MODE_3X3) ? K_3X3 : K_6;
    nw  = (cols >= k) ? cols - k + 1 : 0;
    nrd = 0;
    ed  = 1;
    if (nw > 0) begin
      for (int i = 1; i <= k; i++) begin
        exp_rd[i] = 1; exp_ad[i] = (base + nrd) % AMOD; nrd++;
      end
      t = k + 2;
      for (int w = 0; w < nw; w++) begin
        a = t;
        while (a < MAXC - 4 && !rdy[a]) a++;
        for (int c = t; c <= a; c++) begin exp_val[c] = 1; exp_idx[c] = w; end
        if (w < nw - 1) begin
          exp_rd[a] = 1; exp_ad[a] = (base + nrd) % AMOD; nrd++;
          t = a + 2;
        end else begin
          ed = a + 1;
        end
      end
    end
    for (int c = 0; c <= ed; c++) begin
      exp_tr[c] = pack_tr(exp_rd[c], 10'(exp_ad[c]), (c > 0) && exp_rd[c-1],
                          exp_val[c], 8'(exp_idx[c]), c == ed,
                          (nw > 0) && (c >= 1) && (c < ed),
                          (c == 0) ? prev_mode : mode, (c == 0) ? prev_h3 : h3);
    end

    done_c = -1; n_rd = 0; n_sh = 0; n_win = 0;
    for (int c = 0; c <= ed; c++) begin
      if (c == 0) begin
        bus.i_start = 1'b1; bus.i_mode = mode; bus.i_3x3 = h3;
        bus.i_cols = 8'(cols); bus.i_base_addr = 10'(base);
      end else if (junk) begin
        bus.i_start = 1'($urandom_range(0, 1)); bus.i_mode = 2'($urandom_range(0, 3));
        bus.i_3x3 = 1'($urandom_range(0, 1)); bus.i_cols = 8'($urandom_range(0, 255));
        bus.i_base_addr = 10'($urandom_range(0, AMOD - 1));
      end else begin
        bus.i_start = 1'b0;
      end
      bus.i_pe_ready = rdy[c];
      #1;
      act_tr[c] = pack_tr(bus.o_rd_en, bus.o_rd_addr, bus.o_shift, bus.o_win_valid,
                          bus.o_win_idx, bus.o_done, bus.o_busy, bus.o_mode, bus.o_3x3);
      act_rd[c] = bus.o_rd_en; act_ad[c] = bus.o_rd_addr; act_sh[c] = bus.o_shift;
      if (bus.o_rd_en === 1'b1) n_rd++;
      if (bus.o_shift === 1'b1) n_sh++;
      if (bus.o_win_valid === 1'b1 && rdy[c]) n_win++;
      if (bus.o_done === 1'b1 && done_c < 0) done_c = c;
      @(posedge clk);
      #1;
    end
    bus.i_start = 1'b0;

    fm = -1;
    for (int c = 0; c <= ed; c++) if (fm < 0 && act_tr[c] !== exp_tr[c]) fm = c;
    if (fm < 0) fm = ed;
    check($sformatf("%s trace cyc%0d", tag, fm), 32'(act_tr[fm]), 32'(exp_tr[fm]));
    check($sformatf("%s reads", tag), n_rd, (nw > 0) ? cols : 0);
    check($sformatf("%s shifts", tag), n_sh, (nw > 0) ? cols : 0);
    check($sformatf("%s windows", tag), n_win, nw);
    check($sformatf("%s done_cyc", tag), done_c, ed);
    prev_mode = mode;
    prev_h3   = h3;
  endtask

  task automatic reset_mid_job();
    int bad;
    set_ready_all();
    for (int c = 0; c <= 4; c++) begin
      bus.i_start = (c == 0); bus.i_mode = MODE_6A; bus.i_3x3 = 1'b1;
      bus.i_cols = 8'd20; bus.i_base_addr = 10'h100; bus.i_pe_ready = 1'b1;
      if (c == 4) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.i_start = 1'b0;
    check("rst busy",   32'(bus.o_busy),      32'd0);
    check("rst done",   32'(bus.o_done),      32'd0);
    check("rst rd_en",  32'(bus.o_rd_en),     32'd0);
    check("rst addr",   32'(bus.o_rd_addr),   32'd0);
    check("rst shift",  32'(bus.o_shift),     32'd0);
    check("rst mode",   32'(bus.o_mode),      32'd0);
    check("rst 3x3",    32'(bus.o_3x3),       32'd0);
    check("rst valid",  32'(bus.o_win_valid), 32'd0);
    check("rst idx",    32'(bus.o_win_idx),   32'd0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    check("rst no done/busy after", bad, 0);
    prev_mode = 2'b00;
    prev_h3   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, nr, ns, nwn, quiet;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_mode = 2'b00; bus.i_3x3 = 1'b0;
    bus.i_cols = '0; bus.i_base_addr = '0; bus.i_pe_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",  32'(bus.o_busy),      32'd0);
    check("reset done",  32'(bus.o_done),      32'd0);
    check("reset rd_en", 32'(bus.o_rd_en),     32'd0);
    check("reset valid", 32'(bus.o_win_valid), 32'd0);
    check("reset shift", 32'(bus.o_shift),     32'd0);
    rst = 1'b0;

    set_ready_all();
    run_job("s1", MODE_6A, 1'b0, 8, 'h010, 1'b0, dc, nr, ns, nwn);
    check("s1 done at 13", dc, 13);
    check("s1 read@8 en", 32'(act_rd[8]), 32'd1);
    check("s1 read@8 addr", 32'(act_ad[8]), 32'h016);
    check("s1 read@10 addr", 32'(act_ad[10]), 32'h017);

    run_job("s2", MODE_3X3, 1'b1, 5, 'h055, 1'b0, dc, nr, ns, nwn);
    check("s2 shifts 5", ns, 5);
    check("s2 windows 3", nwn, 3);

    set_ready_gap(10, 13);
    run_job("s3", MODE_6A, 1'b0, 8, 'h010, 1'b0, dc, nr, ns, nwn);
    check("s3 done at 17", dc, 17);
    quiet = 0;
    for (int c = 11; c <= 13; c++) quiet += int'(act_rd[c]) + int'(act_sh[c]);
    check("s3 quiet during hold", quiet, 0);

    set_ready_all();
    run_job("s4", MODE_6B, 1'b0, 4, 'h123, 1'b0, dc, nr, ns, nwn);
    check("s4 done at 1", dc, 1);
    check("s4 no reads", nr, 0);

    run_job("s5", MODE_6C, 1'b0, 6, 'h3FE, 1'b0, dc, nr, ns, nwn);
    check("s5 addr@2", 32'(act_ad[2]), 32'h3FF);
    check("s5 addr@3 wrap", 32'(act_ad[3]), 32'h000);
    check("s5 addr@6", 32'(act_ad[6]), 32'h003);

    run_job("cols0", MODE_3X3, 1'b1, 0, 'h000, 1'b0, dc, nr, ns, nwn);
    run_job("nw1_3x3", MODE_3X3, 1'b0, 3, 'h200, 1'b0, dc, nr, ns, nwn);
    run_job("nw1_6", MODE_6B, 1'b1, 6, 'h3FF, 1'b0, dc, nr, ns, nwn);

    run_job("busy_start", MODE_6A, 1'b1, 10, 'h200, 1'b1, dc, nr, ns, nwn);
    #1;
    check("busy_start mode held", 32'(bus.o_mode), 32'(MODE_6A));
    check("busy_start 3x3 held", 32'(bus.o_3x3), 32'd1);

    reset_mid_job();
    run_job("after_rst", MODE_6C, 1'b0, 9, 'h0F0, 1'b0, dc, nr, ns, nwn);

    for (int j = 0; j < 24; j++) begin
      set_ready_rand(int'($urandom_range(1, 4)));
      run_job($sformatf("rnd%0d", j), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              (j % 8 == 7) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 24)),
              int'($urandom_range(0, AMOD - 1)), 1'($urandom_range(0, 1)),
              dc, nr, ns, nwn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
